// File: rtl/pulp_clock_divider_prog.sv
// pulp_clock_divider_prog
//   Programmable glitch-free integer clock divider. A ratio of 0 or 1 passes
//   clk_i straight through (gated by the enable); a ratio N >= 2 produces a
//   period of N clk_i cycles, floor(N/2) high and the rest low. Ratio updates
//   and disables are applied only on a divided-period boundary.
//
// Parameters
//   DIV_WIDTH   : width of the division ratio (>= 2)
//   DEFAULT_DIV : ratio loaded at reset (< 2**DIV_WIDTH)
//
// Ports
//   clk_i       : source clock
//   rst_ni      : asynchronous active-low reset
//   test_mode_i : forces clk_o = clk_i combinationally
//   en_i        : clock enable, sampled on each rising clk_i edge
//   div_i       : requested ratio
//   div_valid_i : request valid
//   div_ready_o : request can be accepted (no request outstanding)
//   clk_o       : divided / bypassed output clock
module pulp_clock_divider_prog #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] DefaultDiv = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic                 DefaultSel = (DEFAULT_DIV >= 2);

    typedef enum logic [1:0] {
        ST_BYPASS,
        ST_DIV,
        ST_STOPPED
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
    logic [DIV_WIDTH-1:0] pend_div_q;
    logic                 pend_q, pend_d;
    logic                 en_q;
    logic                 clk_div_q, clk_div_d;
    logic                 sel_div_q;
    logic                 byp_en_l;
    logic                 boundary;
    logic                 accept;

    // State register. Reset parks the FSM in STOPPED with the sampled enable
    // cleared, so the first period starts one cycle after the first edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_STOPPED;
            cnt_q      <= '0;
            cur_div_q  <= DefaultDiv;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            en_q       <= 1'b0;
            clk_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            en_q      <= en_i;
            clk_div_q <= clk_div_d;
            if (accept) begin
                pend_div_q <= div_i;
            end
        end
    end

    // Next-state logic. Everything here depends on registers only (accept
    // just arms pend_q), so state_d is stable for the whole clk_i cycle and
    // can be sampled by the falling-edge mux select and the bypass latch.
    always_comb begin
        boundary = 1'b1;
        if (state_q == ST_DIV) begin
            boundary = (cnt_q == (cur_div_q - DIV_WIDTH'(1)));
        end

        accept    = div_valid_i & ~pend_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        if (boundary && pend_q) begin
            cur_div_d = pend_div_q;
            pend_d    = 1'b0;
        end else if (accept) begin
            pend_d = 1'b1;
        end

        state_d = state_q;
        cnt_d   = '0;
        if (boundary) begin
            if (!en_q) begin
                state_d = ST_STOPPED;
            end else if (cur_div_d > DIV_WIDTH'(1)) begin
                state_d = ST_DIV;
            end else begin
                state_d = ST_BYPASS;
            end
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        clk_div_d = (state_d == ST_DIV) && (cnt_d < (cur_div_d >> 1));
    end

    // Mux select follows the mode of the upcoming cycle, but only moves while
    // the divided clock is low; together with clk_i being low at this edge
    // both mux inputs are low whenever the select changes.
    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_div_q <= DefaultSel;
        end else if (!clk_div_q) begin
            sel_div_q <= (state_d == ST_DIV);
        end
    end

    // Bypass gate enable, transparent while clk_i is low so the gated clock
    // can only start or stop on a whole clk_i high phase.
    always_latch begin
        if (!rst_ni) begin
            byp_en_l <= 1'b0;
        end else if (!clk_i) begin
            byp_en_l <= (state_d == ST_BYPASS);
        end
    end

    // Outputs.
    always_comb begin
        div_ready_o = ~pend_q;
        if (test_mode_i) begin
            clk_o = clk_i;
        end else if (sel_div_q) begin
            clk_o = clk_div_q;
        end else begin
            clk_o = clk_i & byp_en_l;
        end
    end

endmodule
